// File: rtl/key_conditioner.sv
// Pushbutton conditioner: per-key synchroniser, debouncer, press/release pulses
// and a step pulse stream with hold-to-auto-repeat.
module key_conditioner #(
  parameter int unsigned N_KEYS          = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned REPEAT_DELAY    = 25000000,
  parameter int unsigned REPEAT_PERIOD   = 5000000,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic              CLOCK_50,
  input  logic              Reset,
  input  logic [N_KEYS-1:0] KEY,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] step
);

  localparam int unsigned DB_W   = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RP_W   = (RP_MAX > 0) ? $clog2(RP_MAX + 1) : 1;

  localparam logic [DB_W-1:0]   DB_LAST     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [RP_W-1:0]   DELAY_LAST  = RP_W'((REPEAT_DELAY > 0) ? REPEAT_DELAY - 1 : 0);
  localparam logic [RP_W-1:0]   PERIOD_LAST = RP_W'((REPEAT_PERIOD > 0) ? REPEAT_PERIOD - 1 : 0);
  localparam logic [N_KEYS-1:0] IDLE_LVL    = KEY_ACTIVE_LOW ? '1 : '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_HOLD
  } state_t;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] w_s;
  logic [N_KEYS-1:0] r_pressed;
  logic [N_KEYS-1:0] r_pressed_d;
  logic [N_KEYS-1:0] w_rise;
  logic [N_KEYS-1:0] w_fall;
  logic [N_KEYS-1:0] r_press_pulse;
  logic [N_KEYS-1:0] r_release_pulse;
  logic [N_KEYS-1:0] r_step;
  logic [DB_W-1:0]   r_db_cnt [N_KEYS];
  logic [RP_W-1:0]   r_rp_cnt [N_KEYS];
  state_t            r_state  [N_KEYS];

  assign w_s    = KEY_ACTIVE_LOW ? ~r_sync2 : r_sync2;
  assign w_rise = r_pressed & ~r_pressed_d;
  assign w_fall = ~r_pressed & r_pressed_d;

  // Synchroniser resets to the released level so reset never looks like a press.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= IDLE_LVL;
      r_sync2 <= IDLE_LVL;
    end else begin
      r_sync1 <= KEY;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_pressed <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) r_db_cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        if (w_s[i] == r_pressed[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_LAST) begin
          r_pressed[i] <= ~r_pressed[i];
          r_db_cnt[i]  <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_pressed_d     <= '0;
      r_press_pulse   <= '0;
      r_release_pulse <= '0;
    end else begin
      r_pressed_d     <= r_pressed;
      r_press_pulse   <= w_rise;
      r_release_pulse <= w_fall;
    end
  end

  // Release is tested before the repeat terminal count so it wins a tie.
  always_ff @(posedge CLOCK_50 or posedge Reset) begin
    if (Reset) begin
      r_step <= '0;
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        r_state[i]  <= S_IDLE;
        r_rp_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_KEYS; i++) begin
        r_step[i] <= 1'b0;
        case (r_state[i])
          S_IDLE: begin
            r_rp_cnt[i] <= '0;
            if (w_rise[i]) begin
              r_step[i] <= 1'b1;
              if (REPEAT_DELAY == 0) r_state[i] <= S_HOLD;
              else                   r_state[i] <= S_DELAY;
            end
          end
          S_DELAY: begin
            if (w_fall[i]) begin
              r_state[i]  <= S_IDLE;
              r_rp_cnt[i] <= '0;
            end else if (r_rp_cnt[i] == DELAY_LAST) begin
              r_step[i]   <= 1'b1;
              r_rp_cnt[i] <= '0;
              r_state[i]  <= S_REPEAT;
            end else begin
              r_rp_cnt[i] <= r_rp_cnt[i] + 1'b1;
            end
          end
          S_REPEAT: begin
            if (w_fall[i]) begin
              r_state[i]  <= S_IDLE;
              r_rp_cnt[i] <= '0;
            end else if (r_rp_cnt[i] == PERIOD_LAST) begin
              r_step[i]   <= 1'b1;
              r_rp_cnt[i] <= '0;
            end else begin
              r_rp_cnt[i] <= r_rp_cnt[i] + 1'b1;
            end
          end
          S_HOLD: begin
            r_rp_cnt[i] <= '0;
            if (w_fall[i]) r_state[i] <= S_IDLE;
          end
          default: begin
            r_state[i]  <= S_IDLE;
            r_rp_cnt[i] <= '0;
          end
        endcase
      end
    end
  end

  assign pressed       = r_pressed;
  assign press_pulse   = r_press_pulse;
  assign release_pulse = r_release_pulse;
  assign step          = r_step;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: stimulus pushes expected pulse events,
// a monitor pops and compares them whenever any pulse output is active.
module tb_key_conditioner;

  localparam int unsigned N  = 4;
  localparam int unsigned DB = 4;
  localparam int unsigned RD = 10;
  localparam int unsigned RP = 3;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] key;
  logic [N-1:0] pressed;
  logic [N-1:0] press_pulse;
  logic [N-1:0] release_pulse;
  logic [N-1:0] step;

  int unsigned cyc    = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    int unsigned  cyc;
    logic [N-1:0] pr;
    logic [N-1:0] rl;
    logic [N-1:0] st;
  } ev_t;

  ev_t q[$];

  key_conditioner #(
    .N_KEYS(N),
    .DEBOUNCE_CYCLES(DB),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RP),
    .KEY_ACTIVE_LOW(1'b1)
  ) dut (
    .CLOCK_50(clk),
    .Reset(rst),
    .KEY(key),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .step(step)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check4(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  function automatic void push(input int unsigned c, input logic [N-1:0] pr,
                               input logic [N-1:0] rl, input logic [N-1:0] st);
    ev_t e;
    e.cyc = c;
    e.pr  = pr;
    e.rl  = rl;
    e.st  = st;
    q.push_back(e);
  endfunction

  // Monitor: merges all expected events due this cycle and compares them.
  initial begin
    logic [N-1:0] epr, erl, est;
    logic         due;
    forever begin
      @(negedge clk);
      epr = '0;
      erl = '0;
      est = '0;
      due = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].cyc == cyc) begin
          epr |= q[i].pr;
          erl |= q[i].rl;
          est |= q[i].st;
          due = 1'b1;
          q.delete(i);
        end else if (q[i].cyc < cyc) begin
          checks++;
          errors++;
          $display("FAIL missing_event at cycle %0d: expected event for cycle %0d never matched", cyc, q[i].cyc);
          q.delete(i);
        end
      end
      if (due || (press_pulse != '0) || (release_pulse != '0) || (step != '0)) begin
        check4("press_pulse", press_pulse, epr);
        check4("release_pulse", release_pulse, erl);
        check4("step", step, est);
      end
    end
  end

  // Caller sits at a negedge. Presses the keys in m, releases them h cycles later;
  // predicted events: press P=k+7, repeats P+RD+n*RP strictly before release R.
  task automatic hold_key(input logic [N-1:0] m, input int unsigned h);
    int unsigned k, p, r;
    k   = cyc + 1;
    p   = k + DB + 3;
    r   = k + h + DB + 3;
    key = key & ~m;
    push(p, m, '0, m);
    for (int unsigned t = p + RD; t < r; t += RP) push(t, '0, '0, m);
    push(r, '0, m, '0);
    while (cyc < r + 3) begin
      @(negedge clk);
      if (cyc == k - 1 + h) key = key | m;
      if (cyc == p - 2) check4("pressed_before_rise", pressed & m, '0);
      if (cyc == p - 1) check4("pressed_after_rise", pressed & m, m);
      if (cyc == r - 2) check4("pressed_before_fall", pressed & m, m);
      if (cyc == r - 1) check4("pressed_after_fall", pressed & m, '0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned k, p;
    rst = 1'b1;
    key = '1;
    repeat (3) @(negedge clk);
    check4("reset_pressed", pressed, '0);
    check4("reset_press_pulse", press_pulse, '0);
    check4("reset_release_pulse", release_pulse, '0);
    check4("reset_step", step, '0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Clean press on key 0
    hold_key(4'b0001, 8);

    // Bounce on key 0: low 3, high 2, low 2, high 1, then held
    key[0] = 1'b0; repeat (3) @(negedge clk);
    key[0] = 1'b1; repeat (2) @(negedge clk);
    key[0] = 1'b0; repeat (2) @(negedge clk);
    key[0] = 1'b1; repeat (1) @(negedge clk);
    hold_key(4'b0001, 12);

    // Long hold on key 1: steps at P, P+10, P+13, P+16, P+19
    hold_key(4'b0010, 20);

    // Early release on key 2: release pulse at P+5, no repeat
    hold_key(4'b0100, 5);

    // Release coinciding with the P+13 repeat slot: release wins
    hold_key(4'b0010, 13);

    // Reset while key 3 is in REPEAT
    k   = cyc + 1;
    p   = k + DB + 3;
    key[3] = 1'b0;
    push(p, 4'b1000, '0, 4'b1000);
    push(p + RD, '0, '0, 4'b1000);
    while (cyc < p + RD + 1) @(negedge clk);
    check4("pressed_before_reset", pressed, 4'b1000);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check4("async_reset_pressed", pressed, '0);
    check4("async_reset_press_pulse", press_pulse, '0);
    check4("async_reset_release_pulse", release_pulse, '0);
    check4("async_reset_step", step, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    hold_key(4'b1000, 20);

    // Keys 0 and 3 together
    hold_key(4'b1001, 17);

    repeat (5) @(negedge clk);
    while (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_event: expected event for cycle %0d never seen", q[0].cyc);
      void'(q.pop_front());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
